// File: rtl/hicore_dtcm_arb_if.sv
// One ICB link (cmd + rsp channels) between an initiator and a target.
// The master modport is the initiator side and the slave modport is the target side.
interface hicore_dtcm_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              icb_cmd_valid;
    logic              icb_cmd_ready;
    logic              icb_cmd_read;
    logic [AW-1:0]     icb_cmd_addr;
    logic [DW-1:0]     icb_cmd_wdata;
    logic [DW/8-1:0]   icb_cmd_wmask;
    logic              icb_rsp_valid;
    logic              icb_rsp_ready;
    logic              icb_rsp_err;
    logic [DW-1:0]     icb_rsp_rdata;

    modport master (
        output icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
        output icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
        input  icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
    );
endinterface

// File: rtl/hicore_dtcm_arb.sv
// Two-master round-robin ICB arbiter in front of the DTCM controller.
// An in-order ID FIFO remembers which master owns each outstanding command.
module hicore_dtcm_arb #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int OUTS_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    hicore_dtcm_arb_if.slave    m0,
    hicore_dtcm_arb_if.slave    m1,
    hicore_dtcm_arb_if.master   s
);
    localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
    localparam int CW = $clog2(OUTS_DEPTH) + 1;

    logic                last_gnt;
    logic                gnt;
    logic [OUTS_DEPTH-1:0] id_fifo;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic                full;
    logic                empty;
    logic                head;
    logic                cmd_hs;
    logic                rsp_hs;
    logic                cmd_rdy;
    logic                rsp_ok;
    logic                g_read;
    logic [AW-1:0]       g_addr;
    logic [DW-1:0]       g_wdata;
    logic [DW/8-1:0]     g_wmask;

    assign full  = (count == CW'(OUTS_DEPTH));
    assign empty = (count == '0);
    assign head  = id_fifo[rd_ptr];

    // Both requesting: the master that did not win last time goes next.
    always_comb begin
        gnt = 1'b0;
        if (m0.icb_cmd_valid && m1.icb_cmd_valid)
            gnt = ~last_gnt;
        else if (m1.icb_cmd_valid)
            gnt = 1'b1;
    end

    always_comb begin
        g_read  = gnt ? m1.icb_cmd_read  : m0.icb_cmd_read;
        g_addr  = gnt ? m1.icb_cmd_addr  : m0.icb_cmd_addr;
        g_wdata = gnt ? m1.icb_cmd_wdata : m0.icb_cmd_wdata;
        g_wmask = gnt ? m1.icb_cmd_wmask : m0.icb_cmd_wmask;
    end

    // Ready depends only on the current fill level, never on a same-cycle pop.
    assign cmd_rdy          = rst_n & s.icb_cmd_ready & ~full;
    assign s.icb_cmd_valid  = rst_n & (m0.icb_cmd_valid | m1.icb_cmd_valid) & ~full;
    assign s.icb_cmd_read   = g_read;
    assign s.icb_cmd_addr   = g_addr;
    assign s.icb_cmd_wdata  = g_wdata;
    assign s.icb_cmd_wmask  = g_wmask;
    assign m0.icb_cmd_ready = cmd_rdy & ~gnt;
    assign m1.icb_cmd_ready = cmd_rdy & gnt;
    assign cmd_hs           = s.icb_cmd_valid & s.icb_cmd_ready;

    // A response arriving with nothing outstanding is ignored.
    assign rsp_ok           = rst_n & ~empty;
    assign m0.icb_rsp_valid = rsp_ok & s.icb_rsp_valid & ~head;
    assign m1.icb_rsp_valid = rsp_ok & s.icb_rsp_valid & head;
    assign s.icb_rsp_ready  = rsp_ok & (head ? m1.icb_rsp_ready : m0.icb_rsp_ready);
    assign m0.icb_rsp_err   = s.icb_rsp_err;
    assign m1.icb_rsp_err   = s.icb_rsp_err;
    assign m0.icb_rsp_rdata = s.icb_rsp_rdata;
    assign m1.icb_rsp_rdata = s.icb_rsp_rdata;
    assign rsp_hs           = s.icb_rsp_valid & s.icb_rsp_ready;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTS_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (cmd_hs) begin
                last_gnt <= gnt;
                wr_ptr   <= ptr_inc(wr_ptr);
            end
            if (rsp_hs)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({cmd_hs, rsp_hs})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_hs)
            id_fifo[wr_ptr] <= gnt;
    end
endmodule
